// File: rtl/sdf_r2_stage_fx.sv
// Fixed-point radix-2 DIF single-path delay-feedback FFT stage with valid/ready on both sides.
// Sums stream out while the delay line refills; twiddled diffs follow, the last group drained in FLUSH.
module sdf_r2_stage_fx #(
   parameter int DATA_W = 16,
   parameter int TW_W   = 16,
   parameter int LOGN   = 8,
   parameter int U      = 1,
   parameter int SCALE  = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [DATA_W-1:0]   in_re,
   input  logic signed [DATA_W-1:0]   in_im,
   input  logic                       inv,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [DATA_W-1:0]   out_re,
   output logic signed [DATA_W-1:0]   out_im,
   output logic                       out_first,
   output logic                       out_last,
   output logic [LOGN-2:0]            tw_addr,
   input  logic signed [TW_W-1:0]     tw_re,
   input  logic signed [TW_W-1:0]     tw_im,
   output logic                       busy
);
   // state | meaning
   // IDLE  | waiting for sample k=0 of a new frame
   // RUN   | accepting samples k=1..N-1
   // FLUSH | input closed, draining the last D twiddled diffs

   localparam int N     = 1 << LOGN;
   localparam int D     = N >> U;
   localparam int AW    = (LOGN - U > 0) ? LOGN - U : 1;
   localparam int DEPTH = 1 << AW;
   localparam int PW    = DATA_W + TW_W + 2;

   localparam logic [LOGN-1:0]          K_LAST = LOGN'(N - 1);
   localparam logic [LOGN-1:0]          K_D    = LOGN'(D);
   localparam logic [LOGN-1:0]          K_DM1  = LOGN'(D - 1);
   localparam logic signed [DATA_W-1:0] S_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] S_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                    state;
   logic [LOGN-1:0]           k;
   logic                      inv_q;
   logic signed [DATA_W-1:0]  dl_re [DEPTH];
   logic signed [DATA_W-1:0]  dl_im [DEPTH];

   logic                      adv, hs, step_fl, g_hi, first_grp, load, sel_sum;
   logic [AW-1:0]             ptr;
   logic signed [DATA_W-1:0]  d_re, d_im, sum_re, sum_im, dif_re, dif_im, mul_re, mul_im;
   logic signed [DATA_W:0]    s_re_w, s_im_w, d_re_w, d_im_w;
   logic signed [TW_W:0]      w_re, w_im;
   logic signed [PW-1:0]      p_re, p_im, r_re, r_im;

   function automatic logic signed [DATA_W-1:0] fit_bf(input logic signed [DATA_W:0] v);
      if (SCALE != 0) return v[DATA_W:1];
      if (v[DATA_W] != v[DATA_W-1]) return v[DATA_W] ? S_MIN : S_MAX;
      return v[DATA_W-1:0];
   endfunction

   function automatic logic signed [DATA_W-1:0] fit_mul(input logic signed [PW-1:0] v);
      logic [PW-DATA_W:0] hi;
      hi = v[PW-1:DATA_W-1];
      if (!(&hi) && (|hi)) return v[PW-1] ? S_MIN : S_MAX;
      return v[DATA_W-1:0];
   endfunction

   assign adv       = !out_valid | out_ready;
   assign in_ready  = rst_n & adv & (state != FLUSH);
   assign hs        = in_valid & in_ready;
   assign step_fl   = (state == FLUSH) & adv;
   assign busy      = (state != IDLE);

   // k mod D addresses the delay line in RUN and doubles as the diff index in FLUSH
   assign ptr       = AW'(k & K_DM1);
   assign g_hi      = k[LOGN-U];
   assign first_grp = (k < K_D);
   assign load      = step_fl | (hs & !first_grp);
   assign sel_sum   = hs & g_hi;
   assign tw_addr   = (LOGN-1)'(ptr) << (U - 1);

   assign d_re   = dl_re[ptr];
   assign d_im   = dl_im[ptr];
   assign s_re_w = (DATA_W+1)'(d_re) + (DATA_W+1)'(in_re);
   assign s_im_w = (DATA_W+1)'(d_im) + (DATA_W+1)'(in_im);
   assign d_re_w = (DATA_W+1)'(d_re) - (DATA_W+1)'(in_re);
   assign d_im_w = (DATA_W+1)'(d_im) - (DATA_W+1)'(in_im);
   assign sum_re = fit_bf(s_re_w);
   assign sum_im = fit_bf(s_im_w);
   assign dif_re = fit_bf(d_re_w);
   assign dif_im = fit_bf(d_im_w);

   // one extra twiddle bit so conjugating the most negative tw_im cannot wrap
   assign w_re = (TW_W+1)'(tw_re);
   assign w_im = inv_q ? -((TW_W+1)'(tw_im)) : (TW_W+1)'(tw_im);
   assign p_re = PW'(d_re) * PW'(w_re) - PW'(d_im) * PW'(w_im);
   assign p_im = PW'(d_re) * PW'(w_im) + PW'(d_im) * PW'(w_re);
   assign r_re = (p_re + PW'(1 << (TW_W - 3))) >>> (TW_W - 2);
   assign r_im = (p_im + PW'(1 << (TW_W - 3))) >>> (TW_W - 2);
   assign mul_re = (U == LOGN) ? d_re : fit_mul(r_re);
   assign mul_im = (U == LOGN) ? d_im : fit_mul(r_im);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         k         <= '0;
         inv_q     <= 1'b0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         if (hs) begin
            if (state == IDLE) inv_q <= inv;
            state <= (k == K_LAST) ? FLUSH : RUN;
            k     <= k + 1'b1;
         end else if (step_fl) begin
            if (k == K_DM1) begin
               state <= IDLE;
               k     <= '0;
            end else begin
               k <= k + 1'b1;
            end
         end
         if (adv) begin
            out_valid <= load;
            if (load) begin
               out_re    <= sel_sum ? sum_re : mul_re;
               out_im    <= sel_sum ? sum_im : mul_im;
               out_first <= hs & (k == K_D);
               out_last  <= step_fl & (k == K_DM1);
            end
         end
      end
   end

   // delay line is not reset; every word is rewritten before it is read in a frame
   always_ff @(posedge clk) begin
      if (hs) begin
         dl_re[ptr] <= g_hi ? dif_re : in_re;
         dl_im[ptr] <= g_hi ? dif_im : in_im;
      end
   end

endmodule

// File: tb/tb_sdf_r2_stage_fx.sv
// Bench for sdf_r2_stage_fx: N=16, U=1, SCALE=0 and SCALE=1 instances driven side by side,
// compared against a direct DIF butterfly model of each frame.
module tb_sdf_r2_stage_fx;
   localparam int DW = 16;
   localparam int TW = 16;
   localparam int LN = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid = 1'b0;
   logic          inv = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_re = '0;
   logic [DW-1:0] in_im = '0;

   logic [1:0]    in_ready_v, out_valid_v, out_first_v, out_last_v, busy_v;
   logic [DW-1:0] out_re_v [2];
   logic [DW-1:0] out_im_v [2];
   logic [LN-2:0] tw_addr_v [2];
   logic [TW-1:0] tw_re_v [2];
   logic [TW-1:0] tw_im_v [2];

   int total = 0;
   int bad = 0;

   int fr_re [16];
   int fr_im [16];
   int exp_re [2][16];
   int exp_im [2][16];
   int cap_re [2][16];
   int cap_im [2][16];

   function automatic int cos_t(input int m);
      case (m)
         0: return 16384;  1: return 15137;  2: return 11585;  3: return 6270;
         4: return 0;      5: return -6270;  6: return -11585; 7: return -15137;
         default: return 0;
      endcase
   endfunction

   function automatic int sin_t(input int m);
      case (m)
         0: return 0;      1: return 6270;   2: return 11585;  3: return 15137;
         4: return 16384;  5: return 15137;  6: return 11585;  7: return 6270;
         default: return 0;
      endcase
   endfunction

   for (genvar s = 0; s < 2; s++) begin : g_dut
      sdf_r2_stage_fx #(.DATA_W(DW), .TW_W(TW), .LOGN(LN), .U(1), .SCALE(s)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .in_valid(in_valid), .in_ready(in_ready_v[s]),
         .in_re(in_re), .in_im(in_im), .inv(inv),
         .out_valid(out_valid_v[s]), .out_ready(out_ready),
         .out_re(out_re_v[s]), .out_im(out_im_v[s]),
         .out_first(out_first_v[s]), .out_last(out_last_v[s]),
         .tw_addr(tw_addr_v[s]), .tw_re(tw_re_v[s]), .tw_im(tw_im_v[s]),
         .busy(busy_v[s])
      );
      assign tw_re_v[s] = TW'(cos_t(int'(tw_addr_v[s])));
      assign tw_im_v[s] = TW'(-sin_t(int'(tw_addr_v[s])));
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
      end
   endtask

   function automatic int sat16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   function automatic int fit(input int v, input int sc);
      if (sc != 0) return v >>> 1;
      return sat16(longint'(v));
   endfunction

   // X[2n] and twiddled X[2n+1] halves of one radix-2 DIF split: sums first, then diffs
   task automatic model(input bit inv_f);
      for (int s = 0; s < 2; s++) begin
         for (int n = 0; n < 8; n++) begin
            int dr, di;
            longint c, w, pr, pi;
            exp_re[s][n] = fit(fr_re[n] + fr_re[n+8], s);
            exp_im[s][n] = fit(fr_im[n] + fr_im[n+8], s);
            dr = fit(fr_re[n] - fr_re[n+8], s);
            di = fit(fr_im[n] - fr_im[n+8], s);
            c  = longint'(cos_t(n));
            w  = inv_f ? longint'(sin_t(n)) : -longint'(sin_t(n));
            pr = longint'(dr) * c - longint'(di) * w;
            pi = longint'(dr) * w + longint'(di) * c;
            exp_re[s][n+8] = sat16((pr + 8192) >>> 14);
            exp_im[s][n+8] = sat16((pi + 8192) >>> 14);
         end
      end
   endtask

   task automatic run_frame(input bit inv_f, input int gap_pct, input int stall_pct);
      int si, oi, cyc, hs8, fo;
      bit stalled;
      logic [63:0] snap [2];
      model(inv_f);
      si = 0; oi = 0; cyc = 0; hs8 = -100; fo = -1; stalled = 1'b0;
      inv = inv_f;
      while (oi < 16 && cyc < 2000) begin
         @(posedge clk); #1;
         out_ready = ($urandom_range(99) >= stall_pct);
         if (si < 16 && $urandom_range(99) >= gap_pct) begin
            in_valid = 1'b1;
            in_re = DW'(fr_re[si]);
            in_im = DW'(fr_im[si]);
         end else begin
            in_valid = 1'b0;
            in_re = DW'($urandom);
            in_im = DW'($urandom);
         end
         @(negedge clk);
         cyc++;
         for (int s = 0; s < 2; s++) begin
            if (stalled)
               chk("hold", {29'd0, out_valid_v[s], out_first_v[s], out_last_v[s], out_re_v[s], out_im_v[s]}, snap[s]);
            snap[s] = {29'd0, out_valid_v[s], out_first_v[s], out_last_v[s], out_re_v[s], out_im_v[s]};
         end
         stalled = out_valid_v[0] && !out_ready;
         if (in_valid && in_ready_v[0]) begin
            if (si == 8) hs8 = cyc;
            si++;
         end
         if (out_valid_v[0] && fo < 0) fo = cyc;
         if (out_valid_v[0] && out_ready) begin
            for (int s = 0; s < 2; s++) begin
               chk($sformatf("data s%0d o%0d", s, oi), {32'd0, out_re_v[s], out_im_v[s]},
                   {32'd0, DW'(exp_re[s][oi]), DW'(exp_im[s][oi])});
               chk($sformatf("flags s%0d o%0d", s, oi), {62'd0, out_first_v[s], out_last_v[s]},
                   {62'd0, oi == 0, oi == 15});
               cap_re[s][oi] = int'($signed(out_re_v[s]));
               cap_im[s][oi] = int'($signed(out_im_v[s]));
            end
            oi++;
         end
      end
      in_valid = 1'b0;
      chk("frame_outputs", 64'(oi), 64'd16);
      chk("latency", 64'(fo - hs8), 64'd1);
      chk("idle_after", {62'd0, busy_v}, 64'd0);
   endtask

   task automatic clear_frame();
      for (int i = 0; i < 16; i++) begin
         fr_re[i] = 0;
         fr_im[i] = 0;
      end
   endtask

   task automatic rand_frame();
      for (int i = 0; i < 16; i++) begin
         fr_re[i] = int'($urandom_range(65535)) - 32768;
         fr_im[i] = int'($urandom_range(65535)) - 32768;
      end
   endtask

   initial begin
      int si, guard;
      repeat (2) @(posedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("rst_in_ready", {62'd0, in_ready_v}, 64'd0);
      chk("rst_out_valid", {62'd0, out_valid_v}, 64'd0);
      chk("rst_busy", {62'd0, busy_v}, 64'd0);
      chk("rst_tw_addr", {58'd0, tw_addr_v[0], tw_addr_v[1]}, 64'd0);
      rst_n = 1'b1;

      clear_frame(); fr_re[0] = 1000;
      run_frame(1'b0, 0, 0);
      chk("impulse_sum0", 64'(cap_re[0][0]), 64'(1000));
      chk("impulse_sum1", 64'(cap_re[0][1]), 64'(0));
      chk("impulse_dif0", 64'(cap_re[0][8]), 64'(1000));

      clear_frame();
      for (int i = 0; i < 16; i++) fr_re[i] = 100;
      run_frame(1'b0, 0, 0);
      chk("const_sum7", 64'(cap_re[0][7]), 64'(200));
      chk("const_dif0", 64'(cap_re[0][8]), 64'(0));

      clear_frame(); fr_re[2] = 100;
      run_frame(1'b0, 0, 0);
      chk("tw_fwd_re", 64'(cap_re[0][10]), 64'(71));
      chk("tw_fwd_im", 64'(cap_im[0][10]), 64'(-71));
      run_frame(1'b1, 0, 0);
      chk("tw_inv_re", 64'(cap_re[0][10]), 64'(71));
      chk("tw_inv_im", 64'(cap_im[0][10]), 64'(71));

      clear_frame(); fr_re[0] = 32767; fr_re[8] = 32767;
      run_frame(1'b0, 0, 0);
      chk("sat_s0", 64'(cap_re[0][0]), 64'(32767));
      chk("sat_s1", 64'(cap_re[1][0]), 64'(32767));
      chk("sat_dif_s0", 64'(cap_re[0][8]), 64'(0));
      chk("sat_dif_s1", 64'(cap_re[1][8]), 64'(0));

      for (int f = 0; f < 6; f++) begin
         rand_frame();
         run_frame(1'($urandom_range(1)), 30, 30);
      end

      // abort a frame after five accepted samples
      rand_frame();
      si = 0; guard = 0;
      while (si < 5 && guard < 100) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         in_valid = 1'b1;
         in_re = DW'(fr_re[si]);
         in_im = DW'(fr_im[si]);
         @(negedge clk);
         guard++;
         if (in_valid && in_ready_v[0]) si++;
      end
      chk("abort_accepted", 64'(si), 64'd5);
      chk("abort_busy", {62'd0, busy_v}, 64'd3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", {62'd0, in_ready_v}, 64'd0);
      chk("mid_rst_busy", {62'd0, busy_v}, 64'd0);
      chk("mid_rst_out", {30'd0, out_valid_v, out_re_v[0], out_im_v[1]}, 64'd0);
      chk("mid_rst_flags", {60'd0, out_first_v, out_last_v}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rand_frame();
      run_frame(1'b0, 30, 30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
